dtc_vote_acc: RTL and testbench

- Sits directly downstream of the decision-tree classifier stage and consumes its 3-bit class predictions.
- Accumulates predictions over a window of WINDOW samples, then selects the majority class.
- Emits the majority class, its vote count and a tie flag through a valid/ready handshake.
- Used to smooth per-sample classifier output into a per-window decision.

---
 rtl/dtc_vote_acc.sv | 174 +++++++++++++++++
 tb/tb_dtc_vote_acc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_vote_acc.sv
// dtc_vote_acc
// Majority-vote accumulator behind the decision-tree classifier. It counts the
// 3-bit class predictions over a window of WINDOW accepted samples, or fewer if
// the window is flushed early. It then scans the eight class counters, one per
// cycle, to find the majority class. The result is presented on a valid/ready
// output and held until it is taken.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_class carries a prediction
//   in_ready   high only while accumulating
//   in_class   class prediction 0..7
//   flush      close the current window early (ignored when it is empty)
//   out_valid  result valid and held
//   out_ready  consumer takes the result
//   out_class  majority class (lowest index wins a tie)
//   out_count  votes received by out_class
//   out_tie    another class has the same vote count as out_class

module dtc_vote_acc #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_class,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_tie
);

    // LOAD is the single cycle between the last scan step and the result
    // register update. It gives the 9-cycle close-to-valid latency.
    typedef enum logic [1:0] {ACCUM, SCAN, LOAD, OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] sampleInc;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       bestClass_q, bestClass_d;
    logic [CNT_W-1:0] bestCount_q, bestCount_d;
    logic             bestTie_q, bestTie_d;
    logic             outValid_q, outValid_d;
    logic [2:0]       outClass_q, outClass_d;
    logic [CNT_W-1:0] outCount_q, outCount_d;
    logic             outTie_q, outTie_d;
    logic             accept;
    logic [CNT_W-1:0] scanCount;

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign sampleInc = sample_q + 1'b1;
    assign scanCount = cnt_q[idx_q];

    assign out_valid = outValid_q;
    assign out_class = outClass_q;
    assign out_count = outCount_q;
    assign out_tie   = outTie_q;

    // Next-state logic. Every register holds by default.
    // ACCUM counts the samples and decides when the window closes.
    // SCAN walks the counters and keeps the best class found so far.
    // LOAD publishes the result. OUTPUT waits for the consumer and then
    // clears the counters for the next window.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        idx_d       = idx_q;
        bestClass_d = bestClass_q;
        bestCount_d = bestCount_q;
        bestTie_d   = bestTie_q;
        outValid_d  = outValid_q;
        outClass_d  = outClass_q;
        outCount_d  = outCount_q;
        outTie_d    = outTie_q;
        for (int k = 0; k < 8; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d[in_class] = cnt_q[in_class] + 1'b1;
                    sample_d        = sampleInc;
                end
                // A flush that arrives together with an accept still closes
                // the window. That accept has already been counted above.
                if ((accept && sampleInc == CNT_W'(WINDOW)) ||
                    (flush && (accept || sample_q != '0))) begin
                    state_d = SCAN;
                    idx_d   = 3'd0;
                end
            end
            SCAN: begin
                if (idx_q == 3'd0) begin
                    bestClass_d = 3'd0;
                    bestCount_d = scanCount;
                    bestTie_d   = 1'b0;
                end else if (scanCount > bestCount_q) begin
                    bestClass_d = idx_q;
                    bestCount_d = scanCount;
                    bestTie_d   = 1'b0;
                end else if (scanCount == bestCount_q && bestCount_q != '0) begin
                    bestTie_d = 1'b1;
                end
                if (idx_q == 3'd7) begin
                    state_d = LOAD;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            LOAD: begin
                outClass_d = bestClass_q;
                outCount_d = bestCount_q;
                outTie_d   = bestTie_q;
                outValid_d = 1'b1;
                state_d    = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    for (int k = 0; k < 8; k++) begin
                        cnt_d[k] = '0;
                    end
                    sample_d   = '0;
                    outValid_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State register. Reset wins over everything and drops any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            sample_q    <= '0;
            idx_q       <= 3'd0;
            bestClass_q <= 3'd0;
            bestCount_q <= '0;
            bestTie_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outClass_q  <= 3'd0;
            outCount_q  <= '0;
            outTie_q    <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            idx_q       <= idx_d;
            bestClass_q <= bestClass_d;
            bestCount_q <= bestCount_d;
            bestTie_q   <= bestTie_d;
            outValid_q  <= outValid_d;
            outClass_q  <= outClass_d;
            outCount_q  <= outCount_d;
            outTie_q    <= outTie_d;
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_dtc_vote_acc.sv
// tb_dtc_vote_acc
// Testbench for dtc_vote_acc. A vote-count model inside the bench tracks the
// per-class tallies, the window length and the fixed close-to-valid delay. The
// model is checked against the DUT on every negative clock edge. Directed
// windows with hand-computed answers pin down the model. A long randomized run
// then covers flush, backpressure and reset.

module tb_dtc_vote_acc;

    localparam int WINDOW = 16;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_class;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_class;
    logic [CNT_W-1:0] out_count;
    logic             out_tie;

    int vectors;
    int miscompares;

    dtc_vote_acc #(.WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_tie   (out_tie)
    );

    // 10-unit clock. Inputs change on the falling edge, and checks run there too.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records one comparison and prints a line if it failed.
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model state.
    // mAcc:  accepting samples.
    // mWait: cycles left before the result appears.
    // mValid/mClass/mCount/mTie: the result the DUT must be showing.
    int mCnt [8];
    int mN;
    bit mAcc;
    int mWait;
    bit mValid;
    int mClass, mCount;
    bit mTie;
    int pClass, pCount;
    bit pTie;
    bit live;

    initial begin
        live = 1'b0;
        mAcc = 1'b1;
        mValid = 1'b0;
        mWait = 0;
        mN = 0;
        for (int k = 0; k < 8; k++) mCnt[k] = 0;
    end

    // Majority of the current tallies. The lowest index wins. It is a tie when
    // more than one class holds the maximum count.
    task automatic computeMajority();
        int best;
        int hits;
        best = 0;
        hits = 0;
        for (int k = 0; k < 8; k++) if (mCnt[k] > best) best = mCnt[k];
        pClass = -1;
        for (int k = 0; k < 8; k++) begin
            if (mCnt[k] == best) begin
                hits++;
                if (pClass < 0) pClass = k;
            end
        end
        pCount = best;
        pTie   = (best > 0) && (hits > 1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) mCnt[k] = 0;
            mN = 0; mAcc = 1'b1; mWait = 0; mValid = 1'b0;
            mClass = 0; mCount = 0; mTie = 1'b0;
            live = 1'b1;
        end else if (live) begin
            if (mAcc) begin
                if (in_valid) begin
                    mCnt[int'(in_class)]++;
                    mN++;
                end
                if (mN == WINDOW || (flush && mN > 0)) begin
                    computeMajority();
                    mAcc  = 1'b0;
                    mWait = 9;
                end
            end else if (mWait > 0) begin
                mWait--;
                if (mWait == 0) begin
                    mValid = 1'b1;
                    mClass = pClass; mCount = pCount; mTie = pTie;
                end
            end else if (mValid && out_ready) begin
                mValid = 1'b0;
                for (int k = 0; k < 8; k++) mCnt[k] = 0;
                mN = 0;
                mAcc = 1'b1;
            end
        end
    end

    // Compare process. Handshake signals are checked every cycle. The result
    // fields are checked only while a result should be on the output.
    always @(negedge clk) begin
        if (live) begin
            checkOutput("in_ready", int'(in_ready), int'(mAcc));
            checkOutput("out_valid", int'(out_valid), int'(mValid));
            if (mValid) begin
                checkOutput("out_class", int'(out_class), mClass);
                checkOutput("out_count", int'(out_count), mCount);
                checkOutput("out_tie", int'(out_tie), int'(mTie));
            end
        end
    end

    task automatic applyStimulus(input bit v, input int c, input bit f, input bit r);
        in_valid  = v;
        in_class  = 3'(c);
        flush     = f;
        out_ready = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sendClass(input int c, input bit r);
        applyStimulus(1'b1, c, 1'b0, r);
        tick();
    endtask

    // Waits (bounded) for out_valid and reports how many edges that took.
    task automatic waitValid(output int edges);
        edges = 0;
        while (!out_valid && edges < 60) begin
            tick();
            edges++;
        end
        if (!out_valid) checkOutput("valid_timeout", 0, 1);
    endtask

    task automatic checkResult(input string tag, input int c, input int n, input int t);
        checkOutput({tag, "_class"}, int'(out_class), c);
        checkOutput({tag, "_count"}, int'(out_count), n);
        checkOutput({tag, "_tie"}, int'(out_tie), t);
    endtask

    int seqA [16] = '{3,3,3,3,3,3,3,3,3,3,5,5,5,5,5,1};
    int edges;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset and idle.
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkResult("reset", 0, 0, 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);

        // Clean majority. The result appears 9 edges after the closing accept.
        for (int i = 0; i < 16; i++) sendClass(seqA[i], 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("scan_in_ready", int'(in_ready), 0);
        waitValid(edges);
        checkOutput("latency_edges", edges, 9);
        checkResult("majority", 3, 10, 0);
        tick();
        checkOutput("after_delivery_in_ready", int'(in_ready), 1);

        // Tie between classes 6 and 2. The lower index is reported.
        for (int i = 0; i < 8; i++) sendClass(6, 1'b1);
        for (int i = 0; i < 8; i++) sendClass(2, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        waitValid(edges);
        checkResult("tie", 2, 8, 1);
        tick();

        // Early flush on the same cycle as the fourth accept.
        sendClass(7, 1'b1); sendClass(7, 1'b1); sendClass(4, 1'b1);
        applyStimulus(1'b1, 4, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        waitValid(edges);
        checkOutput("flush_latency", edges, 9);
        checkResult("flush", 4, 2, 1);
        tick();

        // A flush into an empty window does nothing.
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        tick(); tick(); tick();
        checkOutput("empty_flush_in_ready", int'(in_ready), 1);
        checkOutput("empty_flush_out_valid", int'(out_valid), 0);

        // Backpressure with in_valid held high the whole time.
        for (int i = 0; i < 16; i++) sendClass(1, 1'b0);
        applyStimulus(1'b1, 7, 1'b0, 1'b0);
        waitValid(edges);
        checkResult("bp_first", 1, 16, 0);
        for (int i = 0; i < 20; i++) tick();
        checkResult("bp_held", 1, 16, 0);
        checkOutput("bp_in_ready", int'(in_ready), 0);
        applyStimulus(1'b1, 7, 1'b0, 1'b1);
        tick();
        checkOutput("bp_released_in_ready", int'(in_ready), 1);
        checkOutput("bp_released_valid", int'(out_valid), 0);
        // One sample of class 7 is accepted here, then flushed. A stale
        // counter would make class 1 win instead.
        tick();
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        waitValid(edges);
        checkResult("cleared", 7, 1, 0);
        tick();

        // Reset during the fourth scan cycle.
        for (int i = 0; i < 16; i++) sendClass(3, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_scan_in_ready", int'(in_ready), 1);
        checkOutput("rst_scan_out_valid", int'(out_valid), 0);
        for (int i = 0; i < 16; i++) sendClass(0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        waitValid(edges);
        checkResult("post_rst_scan", 0, 16, 0);
        tick();

        // Reset while a result is held.
        for (int i = 0; i < 16; i++) sendClass(5, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        waitValid(edges);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_out_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkResult("rst_out", 0, 0, 0);
        for (int i = 0; i < 16; i++) sendClass(0, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        waitValid(edges);
        checkResult("post_rst_out", 0, 16, 0);
        tick();

        // Randomized traffic. Classes are sometimes drawn from a narrow set
        // so that close votes and ties occur often.
        for (int i = 0; i < 4000; i++) begin
            int c;
            c = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(2, 3));
            applyStimulus($urandom_range(0, 3) != 0, c, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
